stereo_echo: RTL and testbench
==============================

Name: stereo_echo

Overview:
- Stereo echo/delay effect stage sitting directly downstream of the music player's stereo sample outputs and upstream of the codec interface.
- On each new-sample strobe it reads a delayed sample per channel from a circular buffer and mixes an attenuated copy into the live sample with saturation.
- It writes the mixed result back to the buffer, giving decaying repeated echoes.
- When disabled it is a fixed-latency bypass.

Parameters:
- ADDR_W, 12, buffer address width; buffer depth DEPTH = 2**ADDR_W entries per channel.
- Simulation uses ADDR_W = 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sample_valid  input  1  one-cycle strobe, a new input sample pair is present (new_sample_generated, ~48 kHz)
- sample_in_left  input  16  signed left input sample
- sample_in_right  input  16  signed right input sample
- echo_on  input  1  1 = echo active, 0 = bypass
- delay_sel  input  2  delay length select: L = DEPTH >> delay_sel samples
- decay_sel  input  2  feedback attenuation: arithmetic right shift by decay_sel+1
- sample_out_left  output  16  signed left output sample, registered
- sample_out_right  output  16  signed right output sample, registered
- sample_out_valid  output  1  one-cycle strobe, outputs updated this cycle
- clear_busy  output  1  high while the buffer is being zeroed after reset

Behaviour:
- Storage: two DEPTH x 16 buffers (left, right) with synchronous read and one write port each; pointer ptr [ADDR_W-1:0]; active length register len.
- States: CLEAR, IDLE, READ, MIX.
- Reset: state = CLEAR, ptr = 0, sample_out_left/right = 0, sample_out_valid = 0, clear_busy = 1, len = DEPTH.
- CLEAR: writes 0 to both buffers at address ptr, one entry per cycle, ptr++. After entry DEPTH-1 is written: ptr = 0, clear_busy = 0, state = IDLE (DEPTH cycles total). sample_valid is ignored and outputs hold 0.
- IDLE:
  - On sample_valid, capture both inputs plus echo_on and decay_sel, issue reads at ptr, go to READ.
  - sample_valid in any state other than IDLE is dropped, with no error.
- READ: buffer read data is valid; go to MIX.
- MIX (single cycle), per channel:
  - d = rd_data >>> (decay_sel+1), arithmetic.
  - s = in + d, computed at 17 bits and saturated to [-32768, 32767].
  - echo_on = 1: output = s, write s at ptr.
  - echo_on = 0: output = in, write 0 at ptr, so the echo restarts silent when re-enabled.
  - sample_out_valid = 1 for exactly this cycle.
  - Pointer update: if ptr == len-1, ptr = 0 and len = DEPTH >> delay_sel (sampled now); else ptr++.
  - Return to IDLE.
- Latency: sample_valid at cycle N → sample_out_valid and new outputs at cycle N+2. Outputs hold between strobes.
- delay_sel changes take effect only at the wrap point, so no out-of-range pointer can occur. The first length after reset is DEPTH.
- Echo of input sample k first appears in output k+L, at amplitude in >>> (decay_sel+1). Each further repeat is attenuated by the same shift.
- Saturation: positive overflow → 16'h7FFF; negative overflow → 16'h8000. No wrap-around is ever produced.
- Reset asserted mid-operation (any state): immediate return to CLEAR, the full buffer is re-zeroed, and any in-flight sample is discarded (no valid strobe).

Test Plan (ADDR_W = 4, DEPTH = 16):
1. Reset release → clear_busy high 16 cycles then low. sample_valid during CLEAR → no sample_out_valid, outputs stay 0.
2. echo_on = 0, left = 16'h1234 and right = 16'hFEDC strobed → exactly 2 cycles later sample_out_valid = 1 with 1234/FEDC. Next 20 strobes bypass unchanged.
3. echo_on = 1, delay_sel = 0, decay_sel = 0: impulse 16'h4000 then zeros → outputs 4000, 15×0, 2000, 15×0, 1000, 15×0, 0800…; negative impulse 16'hC000 gives E000, F000 at the same offsets.
4. echo_on = 1, decay_sel = 0, constant input 16'h7000 → second pass 7000 + 3800 saturates to 7FFF. Constant 16'h9000 → second pass saturates to 8000.
5. delay_sel changed 0→2 mid-pass → old length (16) completes, then echoes arrive every 4 samples. Also check two sample_valid pulses 1 cycle apart → second dropped, one output strobe.
6. Reset asserted during READ → no output strobe, clear_busy high 16 cycles, prior echo content gone (impulse-free input yields all-zero output).

Source files
------------

// File: rtl/stereo_echo.sv
// ---------------------------------------------------------------------------
// stereo_echo
//   Stereo echo/delay stage between the music player sample outputs and the
//   codec. Each accepted sample pair reads a delayed sample per channel from a
//   circular buffer, adds an arithmetically attenuated copy to the live sample
//   with saturation, outputs the mix and writes it back so echoes decay over
//   repeated passes. With echo disabled the stage is a fixed-latency bypass
//   and the buffer slot is overwritten with silence.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset
//   sample_valid      one-cycle strobe, new input sample pair present
//   sample_in_left    signed left input sample
//   sample_in_right   signed right input sample
//   echo_on           1 = echo active, 0 = bypass
//   delay_sel         delay length select, L = DEPTH >> delay_sel
//   decay_sel         feedback attenuation, arithmetic shift by decay_sel+1
//   sample_out_left   signed left output sample, registered
//   sample_out_right  signed right output sample, registered
//   sample_out_valid  one-cycle strobe, outputs updated this cycle
//   clear_busy        high while the buffer is zeroed after reset
// ---------------------------------------------------------------------------
module stereo_echo #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_in_left,
    input  logic [15:0] sample_in_right,
    input  logic        echo_on,
    input  logic [1:0]  delay_sel,
    input  logic [1:0]  decay_sel,
    output logic [15:0] sample_out_left,
    output logic [15:0] sample_out_right,
    output logic        sample_out_valid,
    output logic        clear_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_MIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]     r_buf_l [DEPTH];
    logic [15:0]     r_buf_r [DEPTH];

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic [15:0]       r_in_l;
    logic [15:0]       r_in_r;
    logic              r_echo;
    logic [1:0]        r_decay;
    logic [15:0]       r_rd_l;
    logic [15:0]       r_rd_r;
    logic [15:0]       r_out_l;
    logic [15:0]       r_out_r;
    logic              r_out_valid;
    logic              r_clear_busy;

    logic              w_we;
    logic [15:0]       w_wdata_l;
    logic [15:0]       w_wdata_r;
    logic [2:0]        w_shift;
    logic [15:0]       w_d_l;
    logic [15:0]       w_d_r;
    logic [16:0]       w_sum_l;
    logic [16:0]       w_sum_r;
    logic [15:0]       w_mix_l;
    logic [15:0]       w_mix_r;
    logic              w_wrap;
    logic              w_clear_last;

    // Clamp a 17-bit two's-complement sum into the 16-bit range.
    function automatic logic [15:0] sat16(input logic [16:0] s);
        if (s[16] != s[15])
            return s[16] ? 16'h8000 : 16'h7FFF;
        else
            return s[15:0];
    endfunction

    // ---------------- mix datapath ----------------
    always_comb begin
        w_shift = {1'b0, r_decay} + 3'd1;
        w_d_l   = 16'($signed(r_rd_l) >>> w_shift);
        w_d_r   = 16'($signed(r_rd_r) >>> w_shift);
        w_sum_l = {r_in_l[15], r_in_l} + {w_d_l[15], w_d_l};
        w_sum_r = {r_in_r[15], r_in_r} + {w_d_r[15], w_d_r};
        w_mix_l = sat16(w_sum_l);
        w_mix_r = sat16(w_sum_r);
    end

    // The output register is loaded at the end of READ, so during MIX it
    // already holds the saturated mix; that is the value written back.
    always_comb begin
        w_we      = (r_state == S_CLEAR) || (r_state == S_MIX);
        w_wdata_l = '0;
        w_wdata_r = '0;
        if (r_state == S_MIX && r_echo) begin
            w_wdata_l = r_out_l;
            w_wdata_r = r_out_r;
        end
    end

    assign w_wrap       = ({1'b0, r_ptr} == (r_len - 1'b1));
    assign w_clear_last = (r_ptr == '1);

    // ---------------- buffer storage ----------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf_l[r_ptr] <= w_wdata_l;
            r_buf_r[r_ptr] <= w_wdata_r;
        end
        if (r_state == S_IDLE && sample_valid) begin
            r_rd_l <= r_buf_l[r_ptr];
            r_rd_r <= r_buf_r[r_ptr];
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_CLEAR;
        else
            r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (w_clear_last) w_next = S_IDLE;
            S_IDLE:  if (sample_valid) w_next = S_READ;
            S_READ:  w_next = S_MIX;
            S_MIX:   w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    // ---------------- control / output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_len        <= LEN_MAX;
            r_in_l       <= '0;
            r_in_r       <= '0;
            r_echo       <= 1'b0;
            r_decay      <= '0;
            r_out_l      <= '0;
            r_out_r      <= '0;
            r_out_valid  <= 1'b0;
            r_clear_busy <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (w_clear_last)
                        r_clear_busy <= 1'b0;
                end
                S_IDLE: begin
                    if (sample_valid) begin
                        r_in_l  <= sample_in_left;
                        r_in_r  <= sample_in_right;
                        r_echo  <= echo_on;
                        r_decay <= decay_sel;
                    end
                end
                S_READ: begin
                    r_out_l     <= r_echo ? w_mix_l : r_in_l;
                    r_out_r     <= r_echo ? w_mix_r : r_in_r;
                    r_out_valid <= 1'b1;
                end
                S_MIX: begin
                    // New length is only taken at the wrap, so the pointer
                    // can never sit beyond the active length.
                    if (w_wrap) begin
                        r_ptr <= '0;
                        r_len <= LEN_MAX >> delay_sel;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_out_left  = r_out_l;
    assign sample_out_right = r_out_r;
    assign sample_out_valid = r_out_valid;
    assign clear_busy       = r_clear_busy;

endmodule

// File: tb/tb_stereo_echo.sv
// ---------------------------------------------------------------------------
// tb_stereo_echo
//   Scoreboard bench for stereo_echo (ADDR_W = 4, DEPTH = 16). Accepted
//   strobes step a behavioural echo model and queue the expected output pair;
//   a monitor pops and compares whenever sample_out_valid is seen.
// ---------------------------------------------------------------------------
module tb_stereo_echo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        echo_on = 1'b0;
    logic [1:0]  delay_sel = '0;
    logic [1:0]  decay_sel = '0;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;
    logic        clear_busy;

    stereo_echo #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_valid     (sample_valid),
        .sample_in_left   (in_l),
        .sample_in_right  (in_r),
        .echo_on          (echo_on),
        .delay_sel        (delay_sel),
        .decay_sel        (decay_sel),
        .sample_out_left  (out_l),
        .sample_out_right (out_r),
        .sample_out_valid (out_valid),
        .clear_busy       (clear_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    logic [31:0] exp_q[$];

    // Behavioural model: one stored echo per delay slot, ring of length m_len.
    int m_l [DEPTH];
    int m_r [DEPTH];
    int m_ptr;
    int m_len;

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic int sat_mix(input int x, input int y, input int sh);
        int v;
        v = x + (y >>> sh);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_l[i] = 0;
            m_r[i] = 0;
        end
        m_ptr = 0;
        m_len = DEPTH;
    endtask

    task automatic model_step(input logic [15:0] l, input logic [15:0] r,
                              input logic echo, input int decay, input int dsel);
        int xl, xr, ol, orr;
        logic [31:0] e;
        xl = int'($signed(l));
        xr = int'($signed(r));
        if (echo) begin
            ol = sat_mix(xl, m_l[m_ptr], decay + 1);
            orr = sat_mix(xr, m_r[m_ptr], decay + 1);
            m_l[m_ptr] = ol;
            m_r[m_ptr] = orr;
        end else begin
            ol = xl;
            orr = xr;
            m_l[m_ptr] = 0;
            m_r[m_ptr] = 0;
        end
        e = {ol[15:0], orr[15:0]};
        exp_q.push_back(e);
        if (m_ptr == m_len - 1) begin
            m_ptr = 0;
            m_len = DEPTH >> dsel;
        end else begin
            m_ptr++;
        end
    endtask

    // Monitor: compare every output strobe against the queue head.
    always @(negedge clk) begin
        if (out_valid) begin
            logic [31:0] e;
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid got=%h/%h required=no strobe", out_l, out_r);
            end else begin
                e = exp_q.pop_front();
                if ({out_l, out_r} !== e) begin
                    failures++;
                    $display("FAIL sample got=%h/%h required=%h/%h",
                             out_l, out_r, e[31:16], e[15:0]);
                end
            end
        end
    end

    // Issue one strobe from a negedge; returns on the negedge where the DUT
    // is back in idle. Captured controls are scrambled after the strobe.
    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic echo, input logic [1:0] decay);
        in_l = l;
        in_r = r;
        echo_on = echo;
        decay_sel = decay;
        sample_valid = 1'b1;
        model_step(l, r, echo, int'(decay), int'(delay_sel));
        @(negedge clk);
        sample_valid = 1'b0;
        echo_on   = 1'($urandom);
        decay_sel = 2'($urandom);
        in_l      = 16'($urandom);
        in_r      = 16'($urandom);
        check("latency_n1", int'(out_valid), 0);
        @(negedge clk);
        check("latency_n2", int'(out_valid), 1);
        @(negedge clk);
    endtask

    // Count clear_busy cycles after reset release; a stray strobe is issued
    // mid-clear and must be ignored.
    task automatic wait_clear(input string name);
        int cnt;
        cnt = 0;
        while (clear_busy && cnt < 100) begin
            cnt++;
            sample_valid = (cnt == 5);
            in_l = 16'h5555;
            in_r = 16'hAAAA;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check(name, cnt, DEPTH);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nv0;
        model_reset();

        // 1. reset state and clear sequence
        repeat (3) @(negedge clk);
        check("rst_out_l", int'(out_l), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(clear_busy), 1);
        reset = 1'b0;
        wait_clear("clear_cycles");
        check("clear_out_l", int'(out_l), 0);
        check("clear_out_r", int'(out_r), 0);
        check("clear_no_strobe", n_valid, 0);

        // 2. bypass
        send(16'h1234, 16'hFEDC, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++)
            send(16'($urandom), 16'($urandom), 1'b0, 2'($urandom));

        // 3. impulse decay, positive on left, negative on right
        send(16'h4000, 16'hC000, 1'b1, 2'd0);
        for (int i = 0; i < 56; i++)
            send(16'h0000, 16'h0000, 1'b1, 2'd0);

        // 4. saturation
        for (int i = 0; i < DEPTH; i++) send(16'h0, 16'h0, 1'b0, 2'd0);
        for (int i = 0; i < 2 * DEPTH; i++) send(16'h7000, 16'h9000, 1'b1, 2'd0);

        // 5. delay change mid-pass, then short-loop echoes
        for (int i = 0; i < DEPTH; i++) send(16'h0, 16'h0, 1'b0, 2'd0);
        send(16'h4000, 16'hC000, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) send(16'h0, 16'h0, 1'b1, 2'd0);
        delay_sel = 2'd2;
        for (int i = 0; i < 20; i++) send(16'h0, 16'h0, 1'b1, 2'd0);
        send(16'h2000, 16'hE000, 1'b1, 2'd0);
        for (int i = 0; i < 16; i++) send(16'h0, 16'h0, 1'b1, 2'd0);

        // second strobe while busy is dropped
        nv0 = n_valid;
        in_l = 16'h0100;
        in_r = 16'hFF00;
        echo_on = 1'b1;
        decay_sel = 2'd1;
        sample_valid = 1'b1;
        model_step(16'h0100, 16'hFF00, 1'b1, 1, int'(delay_sel));
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        in_l = 16'h7777;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("double_strobe", n_valid - nv0, 1);

        // 6. reset during READ discards the sample and buffer content
        send(16'h3000, 16'hD000, 1'b1, 2'd0);
        send(16'h0, 16'h0, 1'b1, 2'd0);
        nv0 = n_valid;
        in_l = 16'h1111;
        in_r = 16'h2222;
        echo_on = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        delay_sel = 2'd0;
        wait_clear("reclear_cycles");
        check("reset_no_strobe", n_valid - nv0, 0);
        for (int i = 0; i < 20; i++) send(16'h0, 16'h0, 1'b1, 2'($urandom));

        // random mix with occasional length changes
        for (int i = 0; i < 80; i++) begin
            if (i % 12 == 0) delay_sel = 2'($urandom);
            send(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
